// File: rtl/finv_seq.sv
// finv_seq: multi-cycle IEEE-754 single reciprocal (y = 1/x, RNE) with a restoring divider.
// Optional macro FINV_SEQ_FAST_SPECIAL_EN lets zero/denormal/inf/NaN/power-of-two operands skip DIV.
module finv_seq #(
  parameter int R = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        udf
);
  localparam int DIV_CYCLES = 26 / R;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_ROUND, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [31:0]      r_x;
  logic [23:0]      r_rem;
  logic [24:0]      r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid, r_ovf, r_udf;
  logic [31:0]      r_y;

  logic             w_accept, w_skip_div;
  logic             w_s;
  logic [7:0]       w_e;
  logic [22:0]      w_m;
  logic [23:0]      w_mant;
  logic [24:0]      w_p;
  logic [23:0]      w_rem_nxt;
  logic [24:0]      w_q_nxt;
  logic             w_guard, w_sticky, w_rnd;
  logic [23:0]      w_mant_r;
  logic [7:0]       w_exp_div;
  logic [31:0]      w_y;
  logic             w_ovf, w_udf;

  assign in_ready  = (r_state == S_IDLE) & ~rst;
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign ovf       = r_ovf;
  assign udf       = r_udf;

`ifdef FINV_SEQ_FAST_SPECIAL_EN
  assign w_skip_div = (x[30:23] == 8'd0) | (x[30:23] == 8'hFF) | (x[22:0] == 23'd0);
`else
  assign w_skip_div = 1'b0;
`endif

  assign w_s    = r_x[31];
  assign w_e    = r_x[30:23];
  assign w_m    = r_x[22:0];
  assign w_mant = {1'b1, w_m};

  // R restoring steps per cycle; q[25] is always 1 for m != 0, so only q[24:0] is kept.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_rem_nxt = r_rem;
    w_q_nxt   = r_q;
    w_p       = '0;
    for (int i = 0; i < R; i++) begin
      w_p = {w_rem_nxt, 1'b0};
      if (w_p >= {1'b0, w_mant}) begin
        w_p     = w_p - {1'b0, w_mant};
        w_q_nxt = {w_q_nxt[23:0], 1'b1};
      end else begin
        w_q_nxt = {w_q_nxt[23:0], 1'b0};
      end
      w_rem_nxt = w_p[23:0];
    end
  end

  assign w_guard   = r_q[1];
  assign w_sticky  = r_q[0] | (|r_rem);
  assign w_rnd     = w_guard & (w_sticky | r_q[2]);
  assign w_mant_r  = {1'b0, r_q[24:2]} + {23'd0, w_rnd};
  assign w_exp_div = 8'd253 - w_e + {7'd0, w_mant_r[23]};

  always_comb begin
    w_y   = {w_s, w_exp_div, w_mant_r[22:0]};
    w_ovf = 1'b0;
    w_udf = 1'b0;
    if (w_e == 8'd0) begin
      w_y   = {w_s, 8'hFF, 23'd0};
      w_ovf = 1'b1;
    end else if (w_e == 8'hFF) begin
      w_y = (w_m == 23'd0) ? {w_s, 31'd0} : 32'h7FC0_0000;
    end else if (w_m == 23'd0) begin
      w_y   = {w_s, 8'd254 - w_e, 23'd0};
      w_udf = (w_e == 8'd254);
    end else if (w_e >= 8'd253) begin
      w_y   = {w_s, 31'd0};
      w_udf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_skip_div ? S_ROUND : S_DIV;
      S_DIV:   if (r_cnt == '0) w_next = S_ROUND;
      S_ROUND: w_next = S_DONE;
      S_DONE:  if (r_out_valid && out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Result registers: out_valid rises one cycle after DONE is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      if (r_state == S_ROUND) begin
        r_y   <= w_y;
        r_ovf <= w_ovf;
        r_udf <= w_udf;
      end
      if ((r_state == S_DONE) && !r_out_valid) r_out_valid <= 1'b1;
      else if (r_out_valid && out_ready)       r_out_valid <= 1'b0;
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded on accept before being read.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_x   <= x;
      r_rem <= 24'h80_0000;
      r_q   <= '0;
      r_cnt <= CNT_W'(DIV_CYCLES - 1);
    end else if (r_state == S_DIV) begin
      r_rem <= w_rem_nxt;
      r_q   <= w_q_nxt;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_finv_seq.sv
// tb_finv_seq: self-checking bench for finv_seq; reference rounds a double-precision 1/x to single.
module tb_finv_seq;
  localparam int R   = 1;
  localparam int LAT = 2 + 26 / R;
`ifdef FINV_SEQ_FAST_SPECIAL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;
  logic        udf;

  int checks   = 0;
  int failures = 0;

  finv_seq #(.R(R)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  // Reference: exact-enough double quotient, then RNE to single; tiny results flush to signed zero.
  function automatic logic [33:0] ref_finv(input logic [31:0] a);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [63:0] xb, yb;
    real         xr, yr;
    int          ye;
    logic [23:0] mr;
    logic        g, st;
    s = a[31]; e = a[30:23]; m = a[22:0];
    if (e == 8'd0)  return {s, 8'hFF, 23'd0, 1'b1, 1'b0};
    if (e == 8'hFF) return (m == 23'd0) ? {s, 31'd0, 2'b00} : {32'h7FC0_0000, 2'b00};
    xb = {s, 11'(int'(e) - 127 + 1023), m, 29'd0};
    xr = $bitstoreal(xb);
    yr = 1.0 / xr;
    yb = $realtobits(yr);
    ye = int'(yb[62:52]) - 1023 + 127;
    g  = yb[28];
    st = |yb[27:0];
    mr = {1'b0, yb[51:29]} + {23'd0, g & (st | yb[29])};
    if (mr[23]) ye++;
    if (ye <= 0) return {s, 31'd0, 2'b01};
    return {s, ye[7:0], mr[22:0], 2'b00};
  endfunction

  function automatic int exp_lat(input logic [31:0] a);
    if (FAST && (a[30:23] == 8'd0 || a[30:23] == 8'hFF || a[22:0] == 23'd0)) return 2;
    return LAT;
  endfunction

  task automatic start_op(input logic [31:0] xv, output int lat, output bit to);
    in_valid = 1'b1;
    x        = xv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    to = !out_valid;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, y, ovf, udf} !== 36'd0) begin
      failures++;
      $display("FAIL reset_outputs got in_ready=%b out_valid=%b y=%h ovf=%b udf=%b exp all 0",
               in_ready, out_valid, y, ovf, udf);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] xs [3] = '{32'h3F80_0000, 32'h4040_0000, 32'hC000_0000};
    logic [31:0] ys [3] = '{32'h3F80_0000, 32'h3EAA_AAAB, 32'hBF00_0000};
    int lat; bit to;
    for (int i = 0; i < 3; i++) begin
      start_op(xs[i], lat, to);
      checks++;
      if (to || lat != LAT) begin
        failures++;
        $display("FAIL basic_latency x=%h got=%0d timeout=%b exp=%0d", xs[i], lat, to, LAT);
      end
      checks++;
      if ({y, ovf, udf} !== {ys[i], 2'b00}) begin
        failures++;
        $display("FAIL basic_result x=%h got y=%h ovf=%b udf=%b exp y=%h ovf=0 udf=0",
                 xs[i], y, ovf, udf, ys[i]);
      end
      finish_op();
    end
  endtask

  task automatic test_specials();
    logic [31:0] xs [4] = '{32'h0000_0000, 32'h8000_0001, 32'h7F80_0000, 32'h7FC0_0000};
    logic [31:0] ys [4] = '{32'h7F80_0000, 32'hFF80_0000, 32'h0000_0000, 32'h7FC0_0000};
    logic        os [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int lat; bit to;
    for (int i = 0; i < 4; i++) begin
      start_op(xs[i], lat, to);
      checks++;
      if (to || lat != (FAST ? 2 : LAT)) begin
        failures++;
        $display("FAIL special_latency x=%h got=%0d timeout=%b exp=%0d", xs[i], lat, to, FAST ? 2 : LAT);
      end
      checks++;
      if ({y, ovf, udf} !== {ys[i], os[i], 1'b0}) begin
        failures++;
        $display("FAIL special_result x=%h got y=%h ovf=%b udf=%b exp y=%h ovf=%b udf=0",
                 xs[i], y, ovf, udf, ys[i], os[i]);
      end
      finish_op();
    end
  endtask

  task automatic test_underflow();
    logic [31:0] xs [3] = '{32'h7F7F_FFFF, 32'h7F00_0000, 32'hFEC0_0000};
    logic [31:0] ys [3] = '{32'h0000_0000, 32'h0000_0000, 32'h8000_0000};
    int lat; bit to;
    for (int i = 0; i < 3; i++) begin
      start_op(xs[i], lat, to);
      checks++;
      if (to || lat != exp_lat(xs[i])) begin
        failures++;
        $display("FAIL underflow_latency x=%h got=%0d timeout=%b exp=%0d", xs[i], lat, to, exp_lat(xs[i]));
      end
      checks++;
      if ({y, ovf, udf} !== {ys[i], 2'b01}) begin
        failures++;
        $display("FAIL underflow_result x=%h got y=%h ovf=%b udf=%b exp y=%h ovf=0 udf=1",
                 xs[i], y, ovf, udf, ys[i]);
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    int lat; bit to;
    start_op(32'h4040_0000, lat, to);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({out_valid, in_ready, y, ovf, udf} !== {2'b10, 32'h3EAA_AAAB, 2'b00}) begin
        failures++;
        $display("FAIL backpressure_hold cyc=%0d got out_valid=%b in_ready=%b y=%h ovf=%b udf=%b exp 1 0 3eaaaaab 0 0",
                 i, out_valid, in_ready, y, ovf, udf);
      end
      if (i == 3) begin in_valid = 1'b1; x = 32'h3F80_0000; end
      if (i == 4) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL backpressure_release got in_ready=%b out_valid=%b exp in_ready=1 out_valid=0",
               in_ready, out_valid);
    end
    start_op(32'h4000_0000, lat, to);
    checks++;
    if (to || {y, ovf, udf} !== {32'h3F00_0000, 2'b00}) begin
      failures++;
      $display("FAIL backpressure_next got y=%h ovf=%b udf=%b timeout=%b exp y=3f000000 0 0", y, ovf, udf, to);
    end
    finish_op();
  endtask

  task automatic test_random();
    logic [31:0] xv;
    logic [33:0] exp_v;
    int lat; bit to;
    for (int n = 0; n < 1000; n++) begin
      xv = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 5))
          0: xv[30:23] = 8'd0;
          1: xv[30:23] = 8'hFF;
          2: xv[22:0]  = 23'd0;
          3: xv[30:23] = 8'd253;
          4: xv[30:23] = 8'd254;
          default: xv[30:23] = 8'd1;
        endcase
      end
      exp_v = ref_finv(xv);
      start_op(xv, lat, to);
      checks++;
      if (to || lat != exp_lat(xv)) begin
        failures++;
        $display("FAIL random_latency x=%h got=%0d timeout=%b exp=%0d", xv, lat, to, exp_lat(xv));
      end
      checks++;
      if ({y, ovf, udf} !== exp_v) begin
        failures++;
        $display("FAIL random_result x=%h got y=%h ovf=%b udf=%b exp y=%h ovf=%b udf=%b",
                 xv, y, ovf, udf, exp_v[33:2], exp_v[1], exp_v[0]);
      end
      finish_op();
    end
  endtask

  task automatic test_reset_mid_div();
    int seen = 0;
    int lat; bit to;
    in_valid = 1'b1; x = 32'h4040_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, y, in_ready} !== 34'd0) begin
      failures++;
      $display("FAIL abort_outputs got out_valid=%b y=%h in_ready=%b exp 0 0 0", out_valid, y, in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_in_ready got=%b exp=1", in_ready);
    end
    for (int i = 0; i < LAT + 5; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_no_output got out_valid cycles=%0d exp=0", seen);
    end
    start_op(32'hC000_0000, lat, to);
    checks++;
    if (to || {y, ovf, udf} !== {32'hBF00_0000, 2'b00}) begin
      failures++;
      $display("FAIL abort_recover got y=%h ovf=%b udf=%b timeout=%b exp y=bf000000 0 0", y, ovf, udf, to);
    end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_specials();
    test_underflow();
    test_backpressure();
    test_random();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
